// File: rtl/counter_access_ctrl_if.sv
// counter_access_ctrl_if: CPU-side byte bus of one 8254 counter channel.
// master = CPU (drives strobes/address/data), slave = channel front end.
interface counter_access_ctrl_if;
  logic       cs;
  logic       wr;
  logic       rd;
  logic [1:0] a;
  logic [7:0] din;
  logic [7:0] dout;

  modport master (
    output cs,
    output wr,
    output rd,
    output a,
    output din,
    input  dout
  );

  modport slave (
    input  cs,
    input  wr,
    input  rd,
    input  a,
    input  din,
    output dout
  );
endinterface

// File: rtl/counter_access_ctrl.sv
// counter_access_ctrl: per-channel 8254 CPU bus front end.
// Decodes control words, count writes/reads and latch commands.
// Ports: clk; rst (sync, active high);
//   bus: cs/wr/rd/a/din in, dout out (registered read data);
//   count_in: live count from the counter;
//   count_out/count_load: initial count and its one-cycle load strobe;
//   mode/bcd: programmed control-word fields.
module counter_access_ctrl #(
  parameter int unsigned COUNTER_ID = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  counter_access_ctrl_if.slave bus,
  input  logic [15:0]          count_in,
  output logic [15:0]          count_out,
  output logic                 count_load,
  output logic [2:0]           mode,
  output logic                 bcd
);

  typedef enum logic {
    PH_LSB = 1'b0,
    PH_MSB = 1'b1
  } phase_e;

  localparam logic [1:0] ID       = 2'(COUNTER_ID);
  localparam logic [1:0] A_CTRL   = 2'd3;
  localparam logic [1:0] RW_LATCH = 2'b00;
  localparam logic [1:0] RW_LSB   = 2'b01;
  localparam logic [1:0] RW_MSB   = 2'b10;
  localparam logic [1:0] RW_BOTH  = 2'b11;

  logic [7:0]  dout_q, dout_d;
  logic [15:0] cout_q, cout_d;
  logic        load_q, load_d;
  logic [2:0]  mode_q, mode_d;
  logic        bcd_q, bcd_d;
  logic [1:0]  rw_q, rw_d;
  phase_e      wph_q, wph_d;
  phase_e      rph_q, rph_d;
  logic        lat_q, lat_d;
  logic [15:0] ol_q, ol_d;
  logic [7:0]  lsb_q, lsb_d;

  logic [1:0]  cw_sc;
  logic [1:0]  cw_rw;
  logic [2:0]  cw_m;
  logic        cw_bcd;
  logic        wr_en;
  logic        rd_en;
  logic        cw_hit;
  logic        dw_hit;
  logic        dr_hit;
  logic [15:0] src;

  assign cw_sc  = bus.din[7:6];
  assign cw_rw  = bus.din[5:4];
  assign cw_m   = bus.din[3:1];
  assign cw_bcd = bus.din[0];

  // A write strobe always wins; a concurrent read is dropped.
  assign wr_en = bus.cs & bus.wr;
  assign rd_en = bus.cs & bus.rd & ~bus.wr;

  // SC==3 (read-back) can never equal a channel id 0..2.
  assign cw_hit = wr_en & (bus.a == A_CTRL) & (cw_sc == ID);
  assign dw_hit = wr_en & (bus.a == ID);
  assign dr_hit = rd_en & (bus.a == ID);

  assign src = lat_q ? ol_q : count_in;

  always_comb begin
    dout_d = dout_q;
    cout_d = cout_q;
    load_d = 1'b0;
    mode_d = mode_q;
    bcd_d  = bcd_q;
    rw_d   = rw_q;
    wph_d  = wph_q;
    rph_d  = rph_q;
    lat_d  = lat_q;
    ol_d   = ol_q;
    lsb_d  = lsb_q;
    unique case (1'b1)
      cw_hit: begin
        if (cw_rw == RW_LATCH) begin
          // A pending latch is kept until it is read out.
          if (!lat_q) begin
            ol_d  = count_in;
            lat_d = 1'b1;
          end
        end else begin
          mode_d = cw_m;
          bcd_d  = cw_bcd;
          rw_d   = cw_rw;
          wph_d  = PH_LSB;
          rph_d  = PH_LSB;
          lat_d  = 1'b0;
        end
      end
      dw_hit: begin
        case (rw_q)
          RW_LSB: begin
            cout_d = {8'h00, bus.din};
            load_d = 1'b1;
          end
          RW_MSB: begin
            cout_d = {bus.din, 8'h00};
            load_d = 1'b1;
          end
          RW_BOTH: begin
            if (wph_q == PH_LSB) begin
              lsb_d = bus.din;
              wph_d = PH_MSB;
            end else begin
              cout_d = {bus.din, lsb_q};
              wph_d  = PH_LSB;
              load_d = 1'b1;
            end
          end
          default: ;
        endcase
      end
      dr_hit: begin
        case (rw_q)
          RW_LSB: begin
            dout_d = src[7:0];
            lat_d  = 1'b0;
          end
          RW_MSB: begin
            dout_d = src[15:8];
            lat_d  = 1'b0;
          end
          RW_BOTH: begin
            if (rph_q == PH_LSB) begin
              dout_d = src[7:0];
              rph_d  = PH_MSB;
            end else begin
              dout_d = src[15:8];
              rph_d  = PH_LSB;
              lat_d  = 1'b0;
            end
          end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      dout_q <= 8'h00;
      cout_q <= 16'h0000;
      load_q <= 1'b0;
      mode_q <= 3'b000;
      bcd_q  <= 1'b0;
      rw_q   <= RW_BOTH;
      wph_q  <= PH_LSB;
      rph_q  <= PH_LSB;
      lat_q  <= 1'b0;
      ol_q   <= 16'h0000;
      lsb_q  <= 8'h00;
    end else begin
      dout_q <= dout_d;
      cout_q <= cout_d;
      load_q <= load_d;
      mode_q <= mode_d;
      bcd_q  <= bcd_d;
      rw_q   <= rw_d;
      wph_q  <= wph_d;
      rph_q  <= rph_d;
      lat_q  <= lat_d;
      ol_q   <= ol_d;
      lsb_q  <= lsb_d;
    end
  end

  assign bus.dout   = dout_q;
  assign count_out  = cout_q;
  assign count_load = load_q;
  assign mode       = mode_q;
  assign bcd        = bcd_q;

endmodule

// File: tb/tb_counter_access_ctrl.sv
// tb_counter_access_ctrl: directed + random bench for two channels
// (ids 0 and 1) sharing one CPU bus, against a byte-level model.
module tb_counter_access_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cs = 1'b0;
  logic        wr = 1'b0;
  logic        rd = 1'b0;
  logic [1:0]  a = 2'd0;
  logic [7:0]  din = 8'h00;
  logic [15:0] count_in = 16'h0000;

  logic [15:0] cout0, cout1;
  logic        load0, load1;
  logic [2:0]  mode0, mode1;
  logic        bcd0, bcd1;

  int ntot = 0;
  int npass = 0;

  always #5 clk = ~clk;

  counter_access_ctrl_if bus0 ();
  counter_access_ctrl_if bus1 ();

  assign bus0.cs  = cs;
  assign bus0.wr  = wr;
  assign bus0.rd  = rd;
  assign bus0.a   = a;
  assign bus0.din = din;
  assign bus1.cs  = cs;
  assign bus1.wr  = wr;
  assign bus1.rd  = rd;
  assign bus1.a   = a;
  assign bus1.din = din;

  counter_access_ctrl #(.COUNTER_ID(0)) u0 (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus0),
    .count_in   (count_in),
    .count_out  (cout0),
    .count_load (load0),
    .mode       (mode0),
    .bcd        (bcd0)
  );

  counter_access_ctrl #(.COUNTER_ID(1)) u1 (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus1),
    .count_in   (count_in),
    .count_out  (cout1),
    .count_load (load1),
    .mode       (mode1),
    .bcd        (bcd1)
  );

  // Reference model: per channel, bytes written are shifted into an
  // accumulator until the access width (1 or 2 bytes) is reached;
  // reads count bytes returned within the current access.
  logic [1:0]  m_rw[2];
  logic [2:0]  m_mode[2];
  logic        m_bcd[2];
  logic [15:0] m_wacc[2];
  int          m_wn[2];
  int          m_rn[2];
  logic        m_lat[2];
  logic [15:0] m_lval[2];
  logic [7:0]  m_dout[2];
  logic [15:0] m_cout[2];
  logic        m_load[2];

  task automatic mreset(int k);
    m_rw[k]   = 2'b11;
    m_mode[k] = 3'b000;
    m_bcd[k]  = 1'b0;
    m_wacc[k] = 16'h0000;
    m_wn[k]   = 0;
    m_rn[k]   = 0;
    m_lat[k]  = 1'b0;
    m_lval[k] = 16'h0000;
    m_dout[k] = 8'h00;
    m_cout[k] = 16'h0000;
    m_load[k] = 1'b0;
  endtask

  task automatic mstep(int k);
    logic [1:0]  id;
    logic [15:0] src;
    int          need;
    id = 2'(k);
    m_load[k] = 1'b0;
    if (rst) begin
      mreset(k);
      return;
    end
    need = (m_rw[k] == 2'b11) ? 2 : 1;
    if (cs && wr) begin
      if (a == 2'd3 && din[7:6] == id) begin
        if (din[5:4] == 2'b00) begin
          if (!m_lat[k]) begin
            m_lat[k]  = 1'b1;
            m_lval[k] = count_in;
          end
        end else begin
          m_rw[k]   = din[5:4];
          m_mode[k] = din[3:1];
          m_bcd[k]  = din[0];
          m_wn[k]   = 0;
          m_rn[k]   = 0;
          m_lat[k]  = 1'b0;
        end
      end else if (a == id) begin
        m_wacc[k] = {din, m_wacc[k][15:8]};
        m_wn[k]   = m_wn[k] + 1;
        if (m_wn[k] == need) begin
          case (m_rw[k])
            2'b01:   m_cout[k] = {8'h00, din};
            2'b10:   m_cout[k] = {din, 8'h00};
            default: m_cout[k] = m_wacc[k];
          endcase
          m_load[k] = 1'b1;
          m_wn[k]   = 0;
        end
      end
    end else if (cs && rd && a == id) begin
      src = m_lat[k] ? m_lval[k] : count_in;
      if (m_rw[k] == 2'b10 || (m_rw[k] == 2'b11 && m_rn[k] == 1))
        m_dout[k] = src[15:8];
      else
        m_dout[k] = src[7:0];
      m_rn[k] = m_rn[k] + 1;
      if (m_rn[k] == need) begin
        m_rn[k]  = 0;
        m_lat[k] = 1'b0;
      end
    end
  endtask

  task automatic chk(string tag, logic [15:0] obs, logic [15:0] exp);
    ntot++;
    assert (obs === exp) npass++;
    else $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    mstep(0);
    mstep(1);
    #1;
    chk("u0_dout", 16'(bus0.dout), 16'(m_dout[0]));
    chk("u0_cout", cout0, m_cout[0]);
    chk("u0_load", 16'(load0), 16'(m_load[0]));
    chk("u0_mode", 16'(mode0), 16'(m_mode[0]));
    chk("u0_bcd", 16'(bcd0), 16'(m_bcd[0]));
    chk("u1_dout", 16'(bus1.dout), 16'(m_dout[1]));
    chk("u1_cout", cout1, m_cout[1]);
    chk("u1_load", 16'(load1), 16'(m_load[1]));
    chk("u1_mode", 16'(mode1), 16'(m_mode[1]));
    chk("u1_bcd", 16'(bcd1), 16'(m_bcd[1]));
  endtask

  task automatic idle();
    cs = 1'b0; wr = 1'b0; rd = 1'b0;
  endtask

  task automatic wrb(logic [1:0] ad, logic [7:0] d);
    cs = 1'b1; wr = 1'b1; rd = 1'b0; a = ad; din = d;
    cyc();
    idle();
  endtask

  task automatic rdb(logic [1:0] ad);
    cs = 1'b1; wr = 1'b0; rd = 1'b1; a = ad;
    cyc();
    idle();
  endtask

  task automatic do_reset();
    idle();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
  endtask

  initial begin
    mreset(0);
    mreset(1);

    // reset state
    do_reset();
    chk("rst_dout", 16'(bus0.dout), 16'h0000);
    chk("rst_cout", cout0, 16'h0000);
    chk("rst_load", 16'(load0), 16'h0000);
    chk("rst_mode", 16'(mode0), 16'h0000);
    chk("rst_bcd", 16'(bcd0), 16'h0000);

    // RW=11 two-byte write, mode 1
    wrb(2'd3, 8'h32);
    wrb(2'd0, 8'h34);
    chk("lsb_noload", 16'(load0), 16'h0000);
    wrb(2'd0, 8'h12);
    chk("both_cout", cout0, 16'h1234);
    chk("both_load", 16'(load0), 16'h0001);
    chk("both_mode", 16'(mode0), 16'h0001);
    cyc();
    chk("load_1cyc", 16'(load0), 16'h0000);

    // single-byte writes
    wrb(2'd3, 8'h12);
    wrb(2'd0, 8'hA5);
    chk("lsbonly", cout0, 16'h00A5);
    chk("lsbonly_ld", 16'(load0), 16'h0001);
    wrb(2'd3, 8'h22);
    wrb(2'd0, 8'h5A);
    chk("msbonly", cout0, 16'h5A00);
    chk("msbonly_ld", 16'(load0), 16'h0001);

    // latch then two reads, then live read
    wrb(2'd3, 8'h32);
    count_in = 16'hBEEF;
    wrb(2'd3, 8'h00);
    count_in = 16'h0001;
    rdb(2'd0);
    chk("latch_lo", 16'(bus0.dout), 16'h00EF);
    rdb(2'd0);
    chk("latch_hi", 16'(bus0.dout), 16'h00BE);
    rdb(2'd0);
    chk("live_lo", 16'(bus0.dout), 16'h0001);

    // second latch while latched is ignored
    wrb(2'd3, 8'h32);
    count_in = 16'h2222;
    wrb(2'd3, 8'h00);
    count_in = 16'h3333;
    wrb(2'd3, 8'h00);
    rdb(2'd0);
    chk("relatch_lo", 16'(bus0.dout), 16'h0022);
    rdb(2'd0);
    chk("relatch_hi", 16'(bus0.dout), 16'h0022);

    // reset mid-sequence discards half-written count
    wrb(2'd3, 8'h32);
    wrb(2'd0, 8'h34);
    do_reset();
    wrb(2'd3, 8'h32);
    wrb(2'd0, 8'h12);
    chk("rst_half_ld", 16'(load0), 16'h0000);
    wrb(2'd0, 8'h56);
    chk("rst_half_cout", cout0, 16'h5612);
    chk("rst_half_ld2", 16'(load0), 16'h0001);

    // channel 1 ignores channel 0 traffic
    wrb(2'd3, 8'h30);
    chk("u1_other_sc", 16'(mode1), 16'h0000);
    wrb(2'd3, 8'h74);
    chk("u1_mode2", 16'(mode1), 16'h0002);
    wrb(2'd0, 8'h99);
    chk("u1_other_a", 16'(load1), 16'h0000);
    count_in = 16'hABCD;
    rdb(2'd1);
    chk("u1_rd", 16'(bus1.dout), 16'h00CD);
    cs = 1'b1; wr = 1'b1; rd = 1'b1; a = 2'd1; din = 8'h77;
    cyc();
    idle();
    chk("u1_wrrd_dout", 16'(bus1.dout), 16'h00CD);
    wrb(2'd1, 8'h88);
    chk("u1_wrrd_cout", cout1, 16'h8877);
    chk("u1_wrrd_ld", 16'(load1), 16'h0001);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      rst      = ($urandom_range(0, 199) == 0);
      cs       = ($urandom_range(0, 7) != 0);
      wr       = ($urandom_range(0, 2) == 0);
      rd       = ($urandom_range(0, 2) == 0);
      a        = 2'($urandom_range(0, 3));
      din      = 8'($urandom);
      if (a == 2'd3 && $urandom_range(0, 1) == 1)
        din[7:6] = 2'($urandom_range(0, 1));
      count_in = 16'($urandom);
      cyc();
    end
    rst = 1'b0;
    idle();

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
